fetch_unit: RTL and testbench

Instruction-fetch front end driving the instruction port of the unified synchronous memory. It issues word addresses on `addr_i`, tracks the one in-flight read (fixed 1-cycle latency, no read enable on the memory), and presents `{pc, inst}` to decode with a valid/stall handshake. A one-entry hold register absorbs the response that lands during a stall, and a redirect port from execute squashes wrong-path fetches.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end for the unified synchronous memory.
//
// Issues word addresses to the memory instruction port and tracks the one
// read in flight, which has a fixed 1-cycle latency. The fetched instruction
// is presented to decode with a valid/stall handshake. A one-entry hold
// register keeps the response that lands while decode is stalled. A redirect
// from execute squashes wrong-path fetches and restarts the stream.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   When defined, a misaligned redirect target halts fetch and raises
//   if_misalign. Fetch resumes only after an aligned redirect or a reset.
//   When undefined, the low two bits of the redirect target are cleared.
//
// Ports:
//   clk            in   single clock; all state changes on the rising edge
//   rst            in   synchronous active-high reset
//   addr_i         out  fetch address (the fetch_pc register)
//   inst           in   memory read data for the previous cycle's addr_i
//   stall          in   decode cannot accept this cycle
//   redirect_valid in   execute requests a fetch-stream change
//   redirect_pc    in   new fetch address
//   if_valid       out  {if_pc, if_inst} holds a valid instruction
//   if_pc          out  PC of the presented instruction (0 when invalid)
//   if_inst        out  presented instruction (0 when invalid)
//   if_misalign    out  halted on a misaligned redirect (macro builds only)
module fetch_unit #(
  parameter int                  WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [WORD_LEN-1:0] addr_i,
  input  logic [WORD_LEN-1:0] inst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [WORD_LEN-1:0] redirect_pc,
  output logic                if_valid,
  output logic [WORD_LEN-1:0] if_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                if_misalign,
`endif
  output logic [WORD_LEN-1:0] if_inst
);

  logic [WORD_LEN-1:0] fetch_pc_reg;
  logic                infl_valid_reg;
  logic [WORD_LEN-1:0] infl_pc_reg;
  logic                hold_valid_reg;
  logic [WORD_LEN-1:0] hold_pc_reg;
  logic [WORD_LEN-1:0] hold_inst_reg;

  logic [WORD_LEN-1:0] redirect_target;
  logic                run;
  logic                issue;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {RUN, HALT} state_t;

  state_t state_reg;
  logic   misalign_reg;
  logic   redirect_misaligned;

  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redirect_target     = redirect_pc;
  assign run                 = (state_reg == RUN);
  assign if_misalign         = misalign_reg;

  // Only a redirect can change state. An aligned redirect resumes fetch. A
  // misaligned redirect halts fetch, or keeps it halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      misalign_reg <= 1'b0;
    end else if (redirect_valid) begin
      if (redirect_misaligned) begin
        state_reg    <= HALT;
        misalign_reg <= 1'b1;
      end else begin
        state_reg    <= RUN;
        misalign_reg <= 1'b0;
      end
    end
  end
`else
  // Clearing the low bits with a mask keeps every redirect_pc bit in use.
  assign redirect_target = redirect_pc & ~WORD_LEN'(3);
  assign run             = 1'b1;
`endif

  // The address on addr_i is treated as read only in the cycles it is issued.
  // The memory has no read enable, so in every other cycle the read data is
  // simply ignored.
  assign issue  = !stall && !redirect_valid && run;
  assign addr_i = fetch_pc_reg;

  // The hold entry is older than anything in flight, so it is presented
  // first. A redirect kills the presented instruction in the same cycle.
  always_comb begin
    if_valid = (hold_valid_reg || infl_valid_reg) && !redirect_valid;
    if_pc    = '0;
    if_inst  = '0;
    if (if_valid) begin
      if (hold_valid_reg) begin
        if_pc   = hold_pc_reg;
        if_inst = hold_inst_reg;
      end else begin
        if_pc   = infl_pc_reg;
        if_inst = inst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg   <= RESET_PC;
      infl_valid_reg <= 1'b0;
      hold_valid_reg <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_reg   <= redirect_target;
      infl_valid_reg <= 1'b0;
      hold_valid_reg <= 1'b0;
    end else begin
      infl_valid_reg <= issue;
      if (issue) begin
        fetch_pc_reg <= fetch_pc_reg + WORD_LEN'(4);
        infl_pc_reg  <= fetch_pc_reg;
      end
      // A stalled response is lost at the next edge unless it is parked.
      // Nothing issues while stalled, so at most one response needs a slot.
      if (stall && !hold_valid_reg && infl_valid_reg) begin
        hold_valid_reg <= 1'b1;
        hold_pc_reg    <= infl_pc_reg;
        hold_inst_reg  <= inst;
      end else if (if_valid && !stall) begin
        hold_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// The memory returns mem[k] = k one cycle after the address is presented.
// The reference model treats the fetch stream as a queue of issued PCs.
// Decode sees the oldest unconsumed PC together with its memory word. Reset
// and redirects empty the queue. Each stalled cycle leaves the queue alone.
// A directed prologue pins the model with literal values. Randomized
// stall, redirect and reset traffic follows it.
// Builds with FETCH_MISALIGN_TRAP_EN also check if_misalign and halting.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] inst = 32'h0;
  logic [31:0] addr_i;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  int total = 0;
  int bad = 0;

  // Reference model state.
  bit          m_ok = 1'b0;
  bit          m_halt = 1'b0;
  logic [31:0] m_fetch = 32'h0;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .addr_i         (addr_i),
    .inst           (inst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .if_misalign    (if_misalign),
`endif
    .if_inst        (if_inst)
  );

  // Synchronous memory with mem[k] = k.
  always @(posedge clk) inst <= {2'b00, addr_i[31:2]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Model checker. It compares at every negedge after the first reset edge,
  // then advances the model at the next posedge.
  initial begin
    logic        ev;
    logic [31:0] epc;
    forever begin
      @(negedge clk);
      #2;
      if (m_ok) begin
        ev  = (m_q.size() > 0) && !redirect_valid;
        epc = ev ? m_q[0] : 32'h0;
        chk("model addr_i", addr_i, m_fetch);
        chk("model if_valid", {31'b0, if_valid}, {31'b0, ev});
        chk("model if_pc", if_pc, epc);
        chk("model if_inst", if_inst, ev ? {2'b00, epc[31:2]} : 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("model if_misalign", {31'b0, if_misalign}, {31'b0, m_halt});
`endif
      end
      @(posedge clk);
      if (rst) begin
        m_q.delete();
        m_fetch = 32'h0;
        m_halt  = 1'b0;
        m_ok    = 1'b1;
      end else if (m_ok) begin
        if (redirect_valid) begin
          m_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
          m_halt  = (redirect_pc[1:0] != 2'b00);
          m_fetch = redirect_pc;
`else
          m_fetch = {redirect_pc[31:2], 2'b00};
`endif
        end else begin
          if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
          if (!stall && !m_halt) begin
            m_q.push_back(m_fetch);
            m_fetch = m_fetch + 32'd4;
          end
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit s, input bit rv, input logic [31:0] rp);
    @(negedge clk);
    rst            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    #3;
  endtask

  task automatic out(input string nm, input bit v, input logic [31:0] pc, input logic [31:0] in);
    $display("step %s: if_valid=%b if_pc=%h if_inst=%h addr_i=%h",
             nm, if_valid, if_pc, if_inst, addr_i);
    chk({nm, " if_valid"}, {31'b0, if_valid}, {31'b0, v});
    chk({nm, " if_pc"}, if_pc, pc);
    chk({nm, " if_inst"}, if_inst, in);
  endtask

  initial begin
    logic [31:0] rp;
    bit          s, rv, rs;

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    out("reset", 0, 0, 0);
    chk("reset addr_i", addr_i, 32'h0);

    // Streaming from RESET_PC
    cyc(0, 0, 0, 0);  out("c0", 0, 0, 0);  chk("c0 addr_i", addr_i, 32'h0);
    cyc(0, 0, 0, 0);  out("c1", 1, 32'h0, 32'h0);
    cyc(0, 0, 0, 0);  out("c2", 1, 32'h4, 32'h1);

    // Three stall cycles while 8 is presented
    cyc(0, 1, 0, 0);  out("stall0", 1, 32'h8, 32'h2);  chk("stall0 addr_i", addr_i, 32'hC);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);  out("stall2", 1, 32'h8, 32'h2);  chk("stall2 addr_i", addr_i, 32'hC);
    cyc(0, 0, 0, 0);  out("release", 1, 32'h8, 32'h2); chk("release addr_i", addr_i, 32'hC);
    cyc(0, 0, 0, 0);  out("rel+1", 1, 32'hC, 32'h3);
    cyc(0, 0, 0, 0);  out("rel+2", 1, 32'h10, 32'h4);

    // Redirect to 0x40
    cyc(0, 0, 1, 32'h40);  out("redir40", 0, 0, 0);
    cyc(0, 0, 0, 0);       out("redir40+1", 0, 0, 0);  chk("redir40+1 addr_i", addr_i, 32'h40);
    cyc(0, 0, 0, 0);       out("redir40+2", 1, 32'h40, 32'h10);

    // Redirect to the top word, fetch wraps to 0
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);  chk("wrap addr_i", addr_i, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);  out("wrap0", 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);  chk("wrap0 addr_i", addr_i, 32'h0);
    cyc(0, 0, 0, 0);  out("wrap1", 1, 32'h0, 32'h0);

    // Redirect while stalled with the hold entry full
    cyc(0, 1, 0, 0);       out("hold fill", 1, 32'h4, 32'h1);
    cyc(0, 1, 1, 32'h80);  out("redir80 stalled", 0, 0, 0);
    cyc(0, 0, 0, 0);       out("redir80+1", 0, 0, 0);  chk("redir80+1 addr_i", addr_i, 32'h80);
    cyc(0, 0, 0, 0);       out("redir80+2", 1, 32'h80, 32'h20);

    // Reset while the hold entry is full
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);  out("hold full", 1, 32'h84, 32'h21);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);  out("post-reset c0", 0, 0, 0);  chk("post-reset addr_i", addr_i, 32'h0);
    cyc(0, 0, 0, 0);  out("post-reset c1", 1, 32'h0, 32'h0);

    // Misaligned redirect to 0x42
    cyc(0, 0, 1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      out("halted", 0, 0, 0);
      chk("halted if_misalign", {31'b0, if_misalign}, 32'h1);
    end
    chk("halted addr_i", addr_i, 32'h42);
    cyc(0, 0, 1, 32'h80);
    cyc(0, 0, 0, 0);
    chk("resume if_misalign", {31'b0, if_misalign}, 32'h0);
    chk("resume addr_i", addr_i, 32'h80);
    cyc(0, 0, 0, 0);  out("resume", 1, 32'h80, 32'h20);
`else
    cyc(0, 0, 0, 0);  out("redir42+1", 0, 0, 0);  chk("redir42 addr_i", addr_i, 32'h40);
    cyc(0, 0, 0, 0);  out("redir42+2", 1, 32'h40, 32'h10);
`endif

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(0, 99) < 30);
      rv = ($urandom_range(0, 99) < 8);
      rs = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0: rp = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        1: rp = 32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
        2: rp = $urandom;
        default: rp = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      endcase
      cyc(rs, s, rv, rp);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
